// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Increment with wrap that also works for non-power-of-2 counts.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_WIDTH'((int'(ptr_i) + i) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a single FIFO, with burst locking,
// a one-word registered output stage and a lock watchdog.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 18,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]            i_Req_Last,
  output logic [NUM_REQ-1:0]            o_Grant,
  output logic                          o_Data_Valid,
  output logic [DATA_WIDTH-1:0]         o_Data,
  input  logic                          i_Full,
  output logic                          o_Busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_Owner,
  output logic                          o_Lock_Abort
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam int WD_W      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);

  arb_state_e            state_q;
  logic [IDX_WIDTH-1:0]  ptr_q, owner_q;
  logic [WD_W-1:0]       wd_q;
  logic                  dv_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  pick_found;
  logic [IDX_WIDTH-1:0]  pick_idx, grant_idx, owner_nxt;
  logic                  stage_free, owner_req, do_grant, expire;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = i_Req_Data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) u_pick (
    .req_i   (i_Req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign stage_free = !dv_q || !i_Full;
  assign owner_req  = i_Req[owner_q];
  assign owner_nxt  = IDX_WIDTH'(rr_next(int'(owner_q), NUM_REQ));

  // Abort fires in the cycle the idle count would reach LOCK_TIMEOUT; no grant then.
  always_comb begin
    do_grant  = 1'b0;
    grant_idx = owner_q;
    expire    = 1'b0;
    if (!i_Rst) begin
      if (state_q == ARB_IDLE) begin
        if (stage_free && pick_found) begin
          do_grant  = 1'b1;
          grant_idx = pick_idx;
        end
      end else if (owner_req) begin
        do_grant = stage_free;
      end else begin
        expire = (wd_q == WD_LAST);
      end
    end
    grant = '0;
    if (do_grant) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wd_q    <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      if (do_grant) begin
        dv_q    <= 1'b1;
        data_q  <= words[grant_idx];
        owner_q <= grant_idx;
      end else if (dv_q && !i_Full) begin
        dv_q <= 1'b0;
      end
      case (state_q)
        ARB_IDLE: begin
          if (do_grant) begin
            if (i_Req_Last[grant_idx]) begin
              ptr_q <= IDX_WIDTH'(rr_next(int'(grant_idx), NUM_REQ));
            end else begin
              state_q <= ARB_LOCKED;
              wd_q    <= '0;
            end
          end
        end
        default: begin
          if (do_grant) begin
            wd_q <= '0;
            if (i_Req_Last[owner_q]) begin
              state_q <= ARB_IDLE;
              ptr_q   <= owner_nxt;
            end
          end else if (expire) begin
            state_q <= ARB_IDLE;
            ptr_q   <= owner_nxt;
            wd_q    <= '0;
          end else if (!owner_req) begin
            wd_q <= wd_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_Grant      = grant;
  assign o_Data_Valid = dv_q;
  assign o_Data       = data_q;
  assign o_Busy       = (state_q == ARB_LOCKED);
  assign o_Owner      = owner_q;
  assign o_Lock_Abort = expire;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter with a depth-4 FIFO model on its write side.
module tb_fifo_write_arbiter;
  localparam int N = 4, W = 18, LT = 8, DEPTH = 4;

  logic           i_Clk = 1'b0;
  logic           i_Rst;
  logic [N-1:0]   i_Req, i_Req_Last, o_Grant;
  logic [N*W-1:0] i_Req_Data;
  logic           o_Data_Valid, i_Full, o_Busy, o_Lock_Abort;
  logic [W-1:0]   o_Data;
  logic [1:0]     o_Owner;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .LOCK_TIMEOUT(LT)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Req_Data(i_Req_Data),
    .i_Req_Last(i_Req_Last), .o_Grant(o_Grant), .o_Data_Valid(o_Data_Valid),
    .o_Data(o_Data), .i_Full(i_Full), .o_Busy(o_Busy), .o_Owner(o_Owner),
    .o_Lock_Abort(o_Lock_Abort)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0, bad = 0;
  logic [W-1:0] fifo [$];
  logic         rd;
  logic [N-1:0] s_grant;
  logic         s_dv, s_busy, s_abort, s_full;
  logic [W-1:0] s_data;
  logic [1:0]   s_owner;
  logic         wr_ev;
  logic [W-1:0] wr_word;

  typedef struct {
    logic [3:0]  req, last;
    logic [17:0] d;
    logic [3:0]  grant;
    logic        busy, dv;
    logic [17:0] data;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [W-1:0] v);
    i_Req_Data[k*W +: W] = v;
  endtask

  // Sample just before the edge, then advance the FIFO model across it.
  task automatic tick();
    #4;
    s_grant = o_Grant; s_dv = o_Data_Valid; s_data = o_Data; s_full = i_Full;
    s_busy = o_Busy; s_abort = o_Lock_Abort; s_owner = o_Owner;
    @(posedge i_Clk); #1;
    wr_ev = 1'b0;
    if (i_Rst) fifo.delete();
    else begin
      if (rd && fifo.size() > 0) void'(fifo.pop_front());
      if (s_dv && !s_full) begin
        fifo.push_back(s_data); wr_ev = 1'b1; wr_word = s_data;
      end
    end
    i_Full = (fifo.size() >= DEPTH);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1; i_Req = '0; i_Req_Last = '0; rd = 1'b0;
    tick(); tick();
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_dv", 32'(s_dv), 0);
    chk("rst_data", 32'(s_data), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_owner", 32'(s_owner), 0);
    chk("rst_abort", 32'(s_abort), 0);
    i_Rst = 1'b0;
  endtask

  int n, exp_g, m_ptr, m_owner, k;
  bit m_staged, free;
  int rem [N];
  int seq [N];
  logic [W-1:0] expq [$];
  logic [W-1:0] cur [N];

  initial begin
    i_Rst = 1'b1; i_Req = '0; i_Req_Last = '0; i_Req_Data = '0;
    i_Full = 1'b0; rd = 1'b0;

    // Table: single words, rotation with wrap, 3-word burst from req1 vs req2.
    tbl[0]  = '{4'b0001, 4'b1111, 18'h0A5, 4'b0001, 1'b0, 1'b0, 18'h0};
    tbl[1]  = '{4'b0000, 4'b1111, 18'h0,   4'b0000, 1'b0, 1'b1, 18'h0A5};
    tbl[2]  = '{4'b1111, 4'b1111, 18'h200, 4'b0010, 1'b0, 1'b0, 18'h0A5};
    tbl[3]  = '{4'b1111, 4'b1111, 18'h200, 4'b0100, 1'b0, 1'b1, 18'h201};
    tbl[4]  = '{4'b1111, 4'b1111, 18'h200, 4'b1000, 1'b0, 1'b1, 18'h202};
    tbl[5]  = '{4'b1111, 4'b1111, 18'h200, 4'b0001, 1'b0, 1'b1, 18'h203};
    tbl[6]  = '{4'b1111, 4'b1111, 18'h200, 4'b0010, 1'b0, 1'b1, 18'h200};
    tbl[7]  = '{4'b0001, 4'b1111, 18'h300, 4'b0001, 1'b0, 1'b1, 18'h201};
    tbl[8]  = '{4'b0110, 4'b1101, 18'h0FF, 4'b0010, 1'b0, 1'b1, 18'h300};
    tbl[9]  = '{4'b0110, 4'b1101, 18'h100, 4'b0010, 1'b1, 1'b1, 18'h100};
    tbl[10] = '{4'b0110, 4'b1111, 18'h101, 4'b0010, 1'b1, 1'b1, 18'h101};
    tbl[11] = '{4'b0100, 4'b1111, 18'h400, 4'b0100, 1'b0, 1'b1, 18'h102};
    tbl[12] = '{4'b0000, 4'b1111, 18'h0,   4'b0000, 1'b0, 1'b1, 18'h402};
    tbl[13] = '{4'b0000, 4'b1111, 18'h0,   4'b0000, 1'b0, 1'b0, 18'h402};

    do_reset();
    rd = 1'b1;
    for (int i = 0; i < 14; i++) begin
      i_Req = tbl[i].req; i_Req_Last = tbl[i].last;
      for (int j = 0; j < N; j++) set_word(j, tbl[i].d + 18'(j));
      tick();
      chk($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_dv", i), 32'(s_dv), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].data));
      if (i == 1) chk("t1_fifo_words", 32'(fifo.size()), 1);
    end

    // Backpressure: six words from req0 into a FIFO nobody reads.
    do_reset();
    i_Req_Last = '1; i_Req = 4'b0001; n = 1; set_word(0, 18'h501);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_grant[0]) begin
        n++;
        if (n <= 6) set_word(0, 18'h500 + 18'(n)); else i_Req = '0;
      end
    end
    tick();
    chk("bp_grant", 32'(s_grant), 0);
    chk("bp_dv", 32'(s_dv), 1);
    chk("bp_data", 32'(s_data), 32'h505);
    chk("bp_fifo_words", 32'(fifo.size()), 4);
    chk("bp_fifo_head", 32'(fifo[0]), 32'h501);
    rd = 1'b1; tick();
    chk("bp_rd_grant", 32'(s_grant), 0);
    rd = 1'b0; tick();
    chk("bp_w6_grant", 32'(s_grant), 1);
    chk("bp_fifo_words2", 32'(fifo.size()), 4);
    chk("bp_fifo_tail", 32'(fifo[fifo.size()-1]), 32'h505);
    i_Req = '0; tick();
    chk("bp_w6_data", 32'(s_data), 32'h506);
    chk("bp_w6_dv", 32'(s_dv), 1);

    // Watchdog: req3 stops mid-burst while req0 waits.
    do_reset();
    rd = 1'b1; i_Req = 4'b1000; i_Req_Last = 4'b0111; set_word(3, 18'h3AA);
    tick();
    chk("wd_first_grant", 32'(s_grant), 32'b1000);
    i_Req = 4'b0001; i_Req_Last = 4'b1111; set_word(0, 18'h0BB);
    for (int c = 0; c < LT; c++) begin
      tick();
      chk($sformatf("wd_busy%0d", c), 32'(s_busy), 1);
      chk($sformatf("wd_grant%0d", c), 32'(s_grant), 0);
      chk($sformatf("wd_abort%0d", c), 32'(s_abort), (c == LT - 1) ? 1 : 0);
      if (c == 0) chk("wd_owner", 32'(s_owner), 3);
    end
    tick();
    chk("wd_after_busy", 32'(s_busy), 0);
    chk("wd_after_abort", 32'(s_abort), 0);
    chk("wd_after_grant", 32'(s_grant), 1);

    // Reset while locked with a staged word.
    do_reset();
    rd = 1'b0; i_Req = 4'b0100; i_Req_Last = 4'b1011; set_word(2, 18'h2CC);
    tick();
    chk("rl_grant", 32'(s_grant), 32'b0100);
    i_Req = 4'b1111; i_Req_Last = 4'b1111; i_Rst = 1'b1;
    for (int j = 0; j < N; j++) set_word(j, 18'h600 + 18'(j));
    tick();
    chk("rl_dv_before", 32'(s_dv), 1);
    chk("rl_grant_in_rst", 32'(s_grant), 0);
    chk("rl_dv_after", 32'(o_Data_Valid), 0);
    chk("rl_data_after", 32'(o_Data), 0);
    chk("rl_busy_after", 32'(o_Busy), 0);
    chk("rl_owner_after", 32'(o_Owner), 0);
    chk("rl_fifo_words", 32'(fifo.size()), 0);
    i_Rst = 1'b0; tick();
    chk("rl_first_grant", 32'(s_grant), 1);

    // Random traffic against a request-queue model of the arbitration rules.
    do_reset();
    m_ptr = 0; m_owner = -1; m_staged = 1'b0;
    for (int j = 0; j < N; j++) begin rem[j] = 0; seq[j] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int j = 0; j < N; j++) begin
        if (rem[j] == 0 && cyc < 1200 && $urandom_range(0, 3) == 0)
          rem[j] = int'($urandom_range(1, 3));
        i_Req[j] = (rem[j] > 0);
        i_Req_Last[j] = (rem[j] == 1);
        cur[j] = 18'((j << 16) | (seq[j] & 16'hFFFF));
        set_word(j, cur[j]);
      end
      rd = ($urandom_range(0, 2) != 0);
      free = !m_staged || !i_Full;
      exp_g = -1;
      if (free) begin
        if (m_owner >= 0) begin
          if (i_Req[m_owner]) exp_g = m_owner;
        end else begin
          for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (exp_g < 0 && i_Req[k]) exp_g = k;
          end
        end
      end
      tick();
      chk("rnd_grant", 32'(s_grant), (exp_g < 0) ? 0 : (1 << exp_g));
      chk("rnd_busy", 32'(s_busy), (m_owner >= 0) ? 1 : 0);
      chk("rnd_abort", 32'(s_abort), 0);
      if (wr_ev) begin
        if (expq.size() == 0) chk("rnd_spurious_write", 32'(wr_word), 32'hFFFFFFFF);
        else chk("rnd_fifo_data", 32'(wr_word), 32'(expq.pop_front()));
      end
      m_staged = (exp_g >= 0) || (m_staged && s_full);
      if (exp_g >= 0) begin
        expq.push_back(cur[exp_g]);
        if (i_Req_Last[exp_g]) begin m_owner = -1; m_ptr = (exp_g + 1) % N; end
        else m_owner = exp_g;
      end
      for (int j = 0; j < N; j++)
        if (s_grant[j] && rem[j] > 0) begin rem[j]--; seq[j]++; end
    end
    chk("rnd_drained", 32'(expq.size()), 0);
    chk("rnd_pending", 32'(rem[0] + rem[1] + rem[2] + rem[3]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
